// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and defaults for the data-memory arbiter slice.
//   state_t : arbiter FSM state (which requester, if any, has a RAM read
//             completing in the current cycle)
//   req_t   : requester identity, also used as the bit index in grant vectors
//   ADDR_W_DEF / DATA_W_DEF : default RAM word-address and data widths
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CORE = 2'd1,
        RD_EXT  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_EXT  = 1'b1
    } req_t;

    // One-hot grant vector for a requester: bit 0 = core, bit 1 = ext.
    function automatic logic [1:0] req_onehot(input req_t r);
        return (r == REQ_EXT) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone request always wins; on contention the
// requester that did not win most recently is granted. The last winner is
// remembered across idle cycles and resets to the external port, so the core
// wins the first contention after reset.
// Ports:
//   CLOCK, RST_n : clock, asynchronous active-low reset
//   req[1:0]     : request vector, bit 0 = core, bit 1 = ext
//   gnt[1:0]     : one-hot (or zero) grant vector, same bit order
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_t last_gnt_q;
    req_t last_gnt_d;
    req_t winner;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        winner     = REQ_CORE;
        gnt        = 2'b00;
        last_gnt_d = last_gnt_q;

        if (req == 2'b11) begin
            winner = (last_gnt_q == REQ_EXT) ? REQ_CORE : REQ_EXT;
        end else if (req[1]) begin
            winner = REQ_EXT;
        end

        if (req != 2'b00) begin
            gnt        = req_onehot(winner);
            last_gnt_d = winner;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            last_gnt_q <= REQ_EXT;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port synchronous data RAM (1-cycle read latency) between
// the single-cycle core's load/store port and an external loader/debug port.
// The core is stalled while its load is in flight and whenever it loses
// arbitration; stores complete in the grant cycle.
// Ports:
//   CLOCK, RST_n               : clock, asynchronous active-low reset
//   core_rd/core_wr            : core load/store request (rd wins if both)
//   core_addr/core_wdata       : core byte address and store data
//   core_rdata/core_stall      : load data (completion cycle) and PC hold
//   ext_req/ext_we/ext_addr/ext_wdata : external request, held until ext_gnt
//   ext_gnt                    : 1-cycle grant pulse
//   ext_rvalid/ext_rdata       : external read return, cycle after grant
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : RAM interface
//   addr_err                   : pulse the cycle after an out-of-range core
//                                access was granted
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              addr_err
);

    state_t state_q, state_d;
    logic   ext_rvalid_q, ext_rvalid_d;
    logic   core_oor_q, core_oor_d;     // in-flight core load was out of range
    logic   addr_err_q, addr_err_d;

    logic              core_req;
    logic              core_load;
    logic              core_oor;
    logic [ADDR_W-1:0] core_word;
    logic              core_elig;
    logic [1:0]        gnt_vec;
    logic              core_win;
    logic              ext_win;

    // Byte-lane bits are irrelevant to a word-wide RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^core_addr[1:0];

    assign core_req  = core_rd | core_wr;
    assign core_load = core_rd;                 // rd+wr together is a load
    assign core_oor  = |core_addr[31:ADDR_W+2];
    assign core_word = core_addr[ADDR_W+1:2];

    // While the core's own load is completing the core request line still
    // shows that load, so it must not be re-issued.
    assign core_elig = core_req && (state_q != RD_CORE);

    rr_arb2 u_arb (
        .CLOCK (CLOCK),
        .RST_n (RST_n),
        .req   ({ext_req, core_elig}),
        .gnt   (gnt_vec)
    );

    assign core_win = gnt_vec[0];
    assign ext_win  = gnt_vec[1];

    // RAM drive follows the winner; an out-of-range core access still uses
    // its slot but can never write.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (ext_win) begin
            ram_en    = 1'b1;
            ram_we    = ext_we;
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
        end else if (core_win) begin
            ram_en    = 1'b1;
            ram_we    = !core_load && !core_oor;
            ram_addr  = core_word;
            ram_wdata = core_wdata;
        end
    end

    assign ext_gnt    = ext_win;
    // Stall when waiting for the grant, or when the grant starts a load.
    assign core_stall = core_elig && (!core_win || core_load);

    // Read data is only presented in its completion cycle; otherwise 0.
    assign core_rdata = (state_q == RD_CORE && !core_oor_q) ? ram_rdata : '0;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rvalid_q ? ram_rdata : '0;
    assign addr_err   = addr_err_q;

    // At most one grant per cycle, so at most one read is ever outstanding.
    always_comb begin
        state_d    = IDLE;
        core_oor_d = 1'b0;
        addr_err_d = core_win && core_oor;
        if (ext_win && !ext_we) begin
            state_d = RD_EXT;
        end else if (core_win && core_load) begin
            state_d    = RD_CORE;
            core_oor_d = core_oor;
        end
        ext_rvalid_d = (state_d == RD_EXT);
    end

    // Asynchronous reset drops any outstanding read, so no late rvalid.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            ext_rvalid_q <= 1'b0;
            core_oor_q   <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ext_rvalid_q <= ext_rvalid_d;
            core_oor_q   <= core_oor_d;
            addr_err_q   <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench: a directed vector table, hand-written corner sequences
// and a randomized phase compared against a transaction-level reference model
// (shadow memory, queue of pending reads, "who went last" flag).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLOCK = 1'b0;
    logic          RST_n = 1'b0;
    logic          core_rd, core_wr;
    logic [31:0]   core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          addr_err;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK(CLOCK), .RST_n(RST_n),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .addr_err(addr_err)
    );

    always #5 CLOCK = ~CLOCK;

    // Synchronous single-port RAM, 1-cycle read latency.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge CLOCK) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
        logic          ereq;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewdata;
    } stim_t;

    typedef struct packed {
        stim_t         s;
        logic          stall;
        logic          gnt;
        logic          en;
        logic          we;
        logic [AW-1:0] raddr;
        logic [DW-1:0] rwdata;
        logic [DW-1:0] crdata;
        logic          rvalid;
        logic [DW-1:0] erdata;
        logic          err;
    } vec_t;

    task automatic drive(input stim_t s);
        core_rd    = s.rd;
        core_wr    = s.wr;
        core_addr  = s.addr;
        core_wdata = s.wdata;
        ext_req    = s.ereq;
        ext_we     = s.ewe;
        ext_addr   = s.eaddr;
        ext_wdata  = s.ewdata;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          is_core;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] shadow [0:(1<<AW)-1];
    rd_t           m_pend[$];          // reads whose data returns next cycle
    logic          m_last_core;        // most recent grant went to the core
    logic          m_err;              // addr_err expected this cycle
    // values staged by model_check, committed at the clock edge
    stim_t         st_s;
    logic          st_core_win, st_ext_win, st_oor, m_exp_stall;
    logic [AW-1:0] st_word;

    task automatic model_reset();
        m_pend.delete();
        m_last_core = 1'b0;
        m_err       = 1'b0;
    endtask

    task automatic model_check(input stim_t s);
        logic          done_core, done_ext, core_el, ext_el, cw, ew, oor;
        logic [AW-1:0] word;
        logic [DW-1:0] done_data;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        done_core = (m_pend.size() > 0) && m_pend[0].is_core;
        done_ext  = (m_pend.size() > 0) && !m_pend[0].is_core;
        done_data = (m_pend.size() > 0) ? m_pend[0].data : '0;
        oor       = (s.addr >> (AW + 2)) != 0;
        word      = AW'(s.addr >> 2);
        core_el   = (s.rd || s.wr) && !done_core;
        ext_el    = s.ereq;
        cw        = core_el && (!ext_el || !m_last_core);
        ew        = ext_el && !cw;
        e_we      = ew ? s.ewe : (cw && !s.rd && !oor);
        e_addr    = ew ? s.eaddr : (cw ? word : '0);
        e_wdata   = ew ? s.ewdata : (cw ? s.wdata : '0);
        m_exp_stall = core_el && (!cw || s.rd);
        check("model core_stall", core_stall, m_exp_stall);
        check("model ext_gnt",    ext_gnt, ew);
        check("model ram_en",     ram_en, cw || ew);
        check("model ram_we",     ram_we, e_we);
        check("model ram_addr",   ram_addr, e_addr);
        check("model ram_wdata",  ram_wdata, e_wdata);
        check("model core_rdata", core_rdata, done_core ? done_data : '0);
        check("model ext_rvalid", ext_rvalid, done_ext);
        check("model ext_rdata",  ext_rdata, done_ext ? done_data : '0);
        check("model addr_err",   addr_err, m_err);
        st_s = s; st_core_win = cw; st_ext_win = ew; st_oor = oor; st_word = word;
    endtask

    task automatic advance();
        @(posedge CLOCK);
        #1;
        if (m_pend.size() > 0) void'(m_pend.pop_front());
        if (st_core_win && st_s.rd)   m_pend.push_back('{1'b1, st_oor ? '0 : shadow[st_word]});
        if (st_ext_win && !st_s.ewe)  m_pend.push_back('{1'b0, shadow[st_s.eaddr]});
        if (st_ext_win && st_s.ewe)   shadow[st_s.eaddr] = st_s.ewdata;
        if (st_core_win && !st_s.rd && !st_oor) shadow[st_word] = st_s.wdata;
        m_err = st_core_win && st_oor;
        if (st_core_win || st_ext_win) m_last_core = st_core_win;
    endtask

    // Drive, settle to mid-cycle, compare against model; caller may add checks.
    task automatic step(input stim_t s);
        drive(s);
        #4;
        model_check(s);
    endtask

    task automatic do_reset();
        stim_t z;
        z = '0;
        drive(z);
        RST_n = 1'b0;
        model_reset();
        @(posedge CLOCK);
        #1;
        RST_n = 1'b1;
    endtask

    function automatic vec_t mkv(
        input logic rd, input logic wr, input logic [31:0] a, input logic [DW-1:0] wd,
        input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
        input logic stall, input logic gnt, input logic en, input logic we,
        input logic [AW-1:0] ra, input logic [DW-1:0] rwd, input logic [DW-1:0] crd,
        input logic rv, input logic [DW-1:0] erd, input logic err);
        vec_t v;
        v.s      = '{rd, wr, a, wd, er, ew, ea, ewd};
        v.stall  = stall;  v.gnt = gnt; v.en = en; v.we = we;
        v.raddr  = ra;     v.rwdata = rwd; v.crdata = crd;
        v.rvalid = rv;     v.erdata = erd; v.err = err;
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        vec_t  vecs[$];
        stim_t s;
        logic  hold_core, ext_pend;

        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_rdata = '0;
        s = '0;
        drive(s);
        model_reset();

        // ---- reset state ----
        #2;
        check("reset core_stall", core_stall, 0);
        check("reset ext_gnt",    ext_gnt, 0);
        check("reset ram_en",     ram_en, 0);
        check("reset ext_rvalid", ext_rvalid, 0);
        check("reset addr_err",   addr_err, 0);
        check("reset core_rdata", core_rdata, 0);
        @(posedge CLOCK); @(posedge CLOCK); #1;
        RST_n = 1'b1;

        // ---- directed vector table (sequential, from reset) ----
        //            rd wr addr          wdata        er ew ea  ewdata        stall gnt en we ra rwdata        crdata        rv erdata err
        vecs.push_back(mkv(0,0,32'h0,       32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h0,        0,32'h0,0));
        vecs.push_back(mkv(0,0,32'h0,       32'h0,       1,1,5,  32'hDEADBEEF, 0,1,1,1, 5, 32'hDEADBEEF, 32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h14,      32'h0,       0,0,0,  32'h0,        1,0,1,0, 5, 32'h0,        32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h14,      32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'hDEADBEEF, 0,32'h0,0));
        vecs.push_back(mkv(0,1,32'h20,      32'h1234,    0,0,0,  32'h0,        0,0,1,1, 8, 32'h1234,     32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h1014,    32'h0,       0,0,0,  32'h0,        1,0,1,0, 5, 32'h0,        32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h1014,    32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h0,        0,32'h0,1));
        vecs.push_back(mkv(0,0,32'h0,       32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h20,      32'h0,       0,0,0,  32'h0,        1,0,1,0, 8, 32'h0,        32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h20,      32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h1234,     0,32'h0,0));
        vecs.push_back(mkv(0,1,32'h10000020,32'h5555,    0,0,0,  32'h0,        0,0,1,0, 8, 32'h5555,     32'h0,        0,32'h0,0));
        vecs.push_back(mkv(0,0,32'h0,       32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h0,        0,32'h0,1));
        vecs.push_back(mkv(1,0,32'h20,      32'h0,       0,0,0,  32'h0,        1,0,1,0, 8, 32'h0,        32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,0,32'h20,      32'h0,       0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h1234,     0,32'h0,0));
        vecs.push_back(mkv(1,1,32'h20,      32'h9999,    0,0,0,  32'h0,        1,0,1,0, 8, 32'h9999,     32'h0,        0,32'h0,0));
        vecs.push_back(mkv(1,1,32'h20,      32'h9999,    0,0,0,  32'h0,        0,0,0,0, 0, 32'h0,        32'h1234,     0,32'h0,0));

        foreach (vecs[i]) begin
            step(vecs[i].s);
            check($sformatf("vec%0d core_stall", i), core_stall, vecs[i].stall);
            check($sformatf("vec%0d ext_gnt", i),    ext_gnt,    vecs[i].gnt);
            check($sformatf("vec%0d ram_en", i),     ram_en,     vecs[i].en);
            check($sformatf("vec%0d ram_we", i),     ram_we,     vecs[i].we);
            check($sformatf("vec%0d ram_addr", i),   ram_addr,   vecs[i].raddr);
            check($sformatf("vec%0d ram_wdata", i),  ram_wdata,  vecs[i].rwdata);
            check($sformatf("vec%0d core_rdata", i), core_rdata, vecs[i].crdata);
            check($sformatf("vec%0d ext_rvalid", i), ext_rvalid, vecs[i].rvalid);
            check($sformatf("vec%0d ext_rdata", i),  ext_rdata,  vecs[i].erdata);
            check($sformatf("vec%0d addr_err", i),   addr_err,   vecs[i].err);
            advance();
        end

        // ---- contention right after reset: core wins, ext follows in RD_CORE ----
        do_reset();
        s = '{1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 10'd5, 32'h0};
        step(s);
        check("contend core first stall", core_stall, 1);
        check("contend core first gnt",   ext_gnt, 0);
        advance();
        step(s);
        check("contend ext gnt in RD_CORE", ext_gnt, 1);
        check("contend core_rdata",         core_rdata, 32'hDEADBEEF);
        check("contend stall released",     core_stall, 0);
        advance();
        s = '0;
        step(s);
        check("contend ext_rvalid", ext_rvalid, 1);
        check("contend ext_rdata",  ext_rdata, 32'hDEADBEEF);
        advance();

        // ---- three back-to-back ext reads ----
        for (int k = 1; k <= 3; k++) begin
            s = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, AW'(k), DW'(32'hA0 + k)};
            step(s);
            advance();
        end
        for (int k = 1; k <= 4; k++) begin
            s = '0;
            if (k <= 3) s = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, AW'(k), 32'h0};
            step(s);
            check($sformatf("b2b gnt%0d", k), ext_gnt, k <= 3);
            check($sformatf("b2b rvalid%0d", k), ext_rvalid, k > 1);
            if (k > 1) check($sformatf("b2b rdata%0d", k), ext_rdata, DW'(32'hA0 + k - 1));
            advance();
        end

        // ---- reset asserted while in RD_EXT ----
        s = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd2, 32'h0};
        step(s);
        advance();
        check("rst pre rvalid", ext_rvalid, 1);
        s = '0;
        drive(s);
        RST_n = 1'b0;
        #1;
        check("rst immediate rvalid", ext_rvalid, 0);
        check("rst immediate rdata",  ext_rdata, 0);
        model_reset();
        @(posedge CLOCK);
        #1;
        RST_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(s);
            check($sformatf("rst no late rvalid%0d", k), ext_rvalid, 0);
            advance();
        end

        // ---- randomized traffic against the model ----
        hold_core = 1'b0;
        ext_pend  = 1'b0;
        s = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!hold_core) begin
                case ($urandom_range(0, 4))
                    0, 1: begin s.rd = 1'b0; s.wr = 1'b0; end
                    2:    begin s.rd = 1'b1; s.wr = 1'b0; end
                    3:    begin s.rd = 1'b0; s.wr = 1'b1; end
                    default: begin s.rd = 1'b1; s.wr = 1'b1; end
                endcase
                if ($urandom_range(0, 9) == 0) s.addr = $urandom() | 32'h0000_1000;
                else                          s.addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom())};
                s.wdata = $urandom();
            end
            if (!ext_pend) begin
                s.ereq   = ($urandom_range(0, 2) != 0);
                s.ewe    = $urandom_range(0, 1) == 1;
                s.eaddr  = AW'($urandom_range(0, 15));
                s.ewdata = $urandom();
            end
            step(s);
            hold_core = m_exp_stall;
            ext_pend  = s.ereq && !st_ext_win;
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data RAM between two requesters: the core load/store port (ena_rd/ena_wr, ALU address, dataram_wr) and an external loader/debug port. The RAM has a 1-cycle read latency, so the block stalls the single-cycle core (PC hold) on loads and whenever it loses arbitration. The block sits between the core top, the data RAM and the loader, and also returns load data toward the MemtoReg mux.

Parameters:
ADDR_W, 10, RAM word-address width (depth 2^ADDR_W words)
DATA_W, 32, data width

Ports:
CLOCK  input  1  clock
RST_n  input  1  asynchronous active-low reset
core_rd  input  1  core load request (ena_rd)
core_wr  input  1  core store request (ena_wr)
core_addr  input  32  core byte address (ALU result)
core_wdata  input  DATA_W  core store data
core_rdata  output  DATA_W  load data, valid when core_stall=0 in the load's completion cycle
core_stall  output  1  hold PC and register write this cycle
ext_req  input  1  external request, held until ext_gnt
ext_we  input  1  external write (1) / read (0)
ext_addr  input  ADDR_W  external word address
ext_wdata  input  DATA_W  external write data
ext_gnt  output  1  1-cycle grant pulse; request accepted this cycle
ext_rvalid  output  1  external read data valid
ext_rdata  output  DATA_W  external read data
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data (1 cycle after ram_en with ram_we=0)
addr_err  output  1  1-cycle pulse on a core out-of-range access

Behaviour:
- Reset: state=IDLE, last_gnt=EXT. All registered outputs are 0: ext_rvalid, ext_rdata, core_rdata, addr_err. Combinational outputs evaluate to 0 with no requests.
- States:
  - IDLE: no read outstanding.
  - RD_CORE: core read issued last cycle.
  - RD_EXT: ext read issued last cycle.
- Eligibility:
  - Core is eligible in IDLE and RD_EXT when core_rd|core_wr. It is never eligible in RD_CORE, because the same load is completing.
  - Ext is eligible in every state when ext_req=1.
- Arbitration (round-robin, 2-way): a single eligible requester wins. If both are eligible, the one not equal to last_gnt wins. last_gnt updates on every grant.
- Core address: word = core_addr[ADDR_W+1:2], and bits [1:0] are ignored.
  - Out of range when core_addr[31:ADDR_W+2] != 0. The grant is still consumed, ram_we is forced to 0, the read returns 0, and addr_err pulses the cycle after grant.
- core_rd & core_wr both set: treated as a read; the write is suppressed.
- Core store granted: ram_en=1, ram_we=1, core_stall=0, single cycle, state unchanged→IDLE.
- Core load granted: ram_en=1, ram_we=0, core_stall=1, next state RD_CORE.
  - In RD_CORE: core_rdata=ram_rdata (0 if out of range) and core_stall=0.
  - Next state is RD_EXT if ext was granted in that cycle, else IDLE.
- Core eligible but not granted: core_stall=1 and the request is retried next cycle.
- Ext granted: ext_gnt=1 that cycle.
  - Write: a single cycle.
  - Read: next state RD_EXT, where ext_rvalid=1 and ext_rdata=ram_rdata.
- Back-to-back ext reads are allowed: a grant in RD_EXT gives ext_rvalid on consecutive cycles.
- The ram_* outputs are combinational from the arbitration result. ram_wdata/ram_addr hold the winner's values, and are 0 when no grant.
- Reset asserted mid-operation: immediate return to IDLE with every output at its reset value. Any outstanding read is discarded and no ext_rvalid is issued for it.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, RD_CORE, RD_EXT}
  - requester enum {REQ_CORE, REQ_EXT}
  - ADDR_W default constant
- Sub-module rr_arb2: 2-request round-robin with last_gnt register; outputs the grant vector.

Test Plan:
- Ext write to addr 5 with 0xDEADBEEF, then core load from byte address 0x14 -> ext_gnt pulses; core_stall=1 for one cycle; next cycle core_rdata=0xDEADBEEF, stall=0.
- Core store to 0x20 (data 0x1234) with no contention -> ram_we=1, ram_addr=8, core_stall=0 in the same cycle.
- Core load and ext read both requesting at reset -> core wins (last_gnt=EXT) and ext_gnt=0. Ext is granted in RD_CORE, and ext_rvalid follows the next cycle.
- Core load from 0x0000_1000 (ADDR_W=10) -> ram_we=0, core_rdata=0, addr_err pulses once, stall sequence unchanged.
- Three back-to-back ext reads at addresses 1, 2, 3 -> ext_gnt on 3 consecutive cycles; ext_rvalid on the following 3 cycles with matching data.
- RST_n asserted in RD_EXT -> ext_rvalid=0 immediately, state=IDLE, no late data pulse after release.
